dmem_responder: RTL and testbench

Memory-side responder for the CPU's data-memory port. It accepts load/store requests over a valid/ready handshake and holds them for a programmable access latency. Each accepted request returns exactly one response pulse carrying read data or a write acknowledge. It replaces the zero-latency combinational data memory so the pipeline's stall and forwarding logic can be exercised against a realistic multi-cycle memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 10;
    localparam int MAX_LATENCY = 15;
    localparam int REQ_ADDR_W  = 16;

    // IDLE: nothing in flight; WAIT: counting down latency; RESP: response presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word-addressed storage with synchronous write and an enabled, registered read.
// A read and write to the same address on one edge returns the old contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Storage update and read capture; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time over
// valid/ready and returns a single response pulse LATENCY cycles later.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic             LAT_ONE  = (LATENCY == 1);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_we;
    logic              r_err;
    logic              w_ready;
    logic              w_accept;
    logic              w_oor;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [DATA_W-1:0] w_arr_rdata;

    // Ready depends only on registered state; reset blocks acceptance on its edge
    assign w_ready  = (r_state == IDLE) || (r_state == RESP);
    assign w_accept = req_valid && w_ready && rst_n;
    assign w_oor    = |req_addr[REQ_ADDR_W-1:ADDR_W];
    assign w_arr_we = w_accept && req_we && !w_oor;
    assign w_arr_re = w_accept && !req_we && !w_oor;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (req_addr[ADDR_W-1:0]),
        .i_wdata (req_wdata),
        .o_rdata (w_arr_rdata)
    );

    // State and latency counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LAT_ONE) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Stage the request kind and range error alongside the array's read capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_we  <= req_we;
            r_err <= w_oor;
        end else begin
            r_we  <= r_we;
            r_err <= r_err;
        end
    end

    // Outputs decoded from registered state and staging; data forced to 0 off-response
    always_comb begin
        req_ready  = w_ready;
        busy       = (r_state != IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        if (r_state == RESP) begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            if (!r_we && !r_err) begin
                resp_rdata = w_arr_rdata;
            end else begin
                resp_rdata = '0;
            end
        end else begin
            resp_valid = 1'b0;
        end
    end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (LATENCY 2,1,4,3) with independent
// stimulus, a per-instance timeline/memory reference model, directed scenarios
// and a randomized phase.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n      [4];
    logic        req_valid  [4];
    logic        req_ready  [4];
    logic        req_we     [4];
    logic [15:0] req_addr   [4];
    logic [15:0] req_wdata  [4];
    logic        resp_valid [4];
    logic [15:0] resp_rdata [4];
    logic        resp_err   [4];
    logic        busy       [4];

    int n_total = 0;
    int n_bad   = 0;

    function automatic int lat_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3;
        dmem_responder #(.DATA_W(16), .ADDR_W(10), .LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted request is a record with the edge after which its response
    // is shown; the model only reasons about those edge numbers.
    int          ecount = 0;
    bit          minit  [4];
    bit          pend   [4];
    int          due    [4];
    logic [15:0] ex_d   [4];
    bit          ex_err [4];
    bit          ex_dk  [4];
    logic [15:0] mmem   [4][1024];
    bit          mknown [4][1024];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bit rdy_m;
            bit oor;
            int a;
            rdy_m = !pend[i] || (due[i] == ecount);
            if (!rst_n[i]) begin
                pend[i]  = 1'b0;
                minit[i] = 1'b1;
            end else if (minit[i]) begin
                if (pend[i] && due[i] <= ecount) pend[i] = 1'b0;
                if (req_valid[i] && rdy_m) begin
                    a   = int'(req_addr[i] % 16'd1024);
                    oor = (req_addr[i] >= 16'd1024);
                    ex_err[i] = oor;
                    ex_dk[i]  = 1'b1;
                    if (req_we[i]) begin
                        ex_d[i] = 16'h0000;
                        if (!oor) begin
                            mmem[i][a]   = req_wdata[i];
                            mknown[i][a] = 1'b1;
                        end
                    end else if (oor) begin
                        ex_d[i] = 16'h0000;
                    end else begin
                        ex_d[i]  = mmem[i][a];
                        ex_dk[i] = mknown[i][a];
                    end
                    pend[i] = 1'b1;
                    due[i]  = ecount + lat_of(i);
                end
            end
        end
        ecount++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (minit[i]) begin
                bit ev;
                ev = pend[i] && (due[i] == ecount);
                check_eq($sformatf("m_valid%0d", i), resp_valid[i], ev);
                check_eq($sformatf("m_ready%0d", i), req_ready[i], !pend[i] || (due[i] == ecount));
                check_eq($sformatf("m_busy%0d", i), busy[i], pend[i]);
                if (ev) check_eq($sformatf("m_err%0d", i), resp_err[i], ex_err[i]);
                if (!(ev && !ex_dk[i]))
                    check_eq($sformatf("m_rdata%0d", i), resp_rdata[i], ev ? ex_d[i] : 16'h0000);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        logic got;
        got          = 1'b0;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            got = req_ready[i];
            @(posedge clk);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        check_eq("accept", got, 1'b1);
    endtask

    task automatic wait_resp(input int i, output int lat);
        lat = 1;
        while (!resp_valid[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int acc_e[$];
    int rsp_e[$];

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = 16'h0000; req_wdata[i] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_ready", req_ready[i], 1'b1);
            check_eq("rst_valid", resp_valid[i], 1'b0);
            check_eq("rst_busy", busy[i], 1'b0);
            check_eq("rst_rdata", resp_rdata[i], 16'h0000);
        end

        // write then read, LATENCY 2
        issue(0, 1'b1, 16'h0005, 16'hBEEF);
        wait_resp(0, lat);
        check_eq("wr_lat", lat, 2);
        check_eq("wr_rdata", resp_rdata[0], 16'h0000);
        check_eq("wr_err", resp_err[0], 1'b0);
        issue(0, 1'b0, 16'h0005, 16'h0000);
        wait_resp(0, lat);
        check_eq("rd_lat", lat, 2);
        check_eq("rd_data", resp_rdata[0], 16'hBEEF);

        // pipelined accept in RESP, LATENCY 1
        req_we[1] = 1'b1; req_addr[1] = 16'h0010; req_wdata[1] = 16'h1234; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("p_st_valid", resp_valid[1], 1'b1);
        check_eq("p_st_rdata", resp_rdata[1], 16'h0000);
        check_eq("p_ready", req_ready[1], 1'b1);
        req_we[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check_eq("p_ld_valid", resp_valid[1], 1'b1);
        check_eq("p_ld_rdata", resp_rdata[1], 16'h1234);

        // out of range store must not alias onto address 0
        issue(0, 1'b1, 16'h0000, 16'h00A5);
        wait_resp(0, lat);
        issue(0, 1'b1, 16'h0400, 16'hFFFF);
        wait_resp(0, lat);
        check_eq("oor_err", resp_err[0], 1'b1);
        issue(0, 1'b0, 16'h0000, 16'h0000);
        wait_resp(0, lat);
        check_eq("oor_rd", resp_rdata[0], 16'h00A5);
        check_eq("oor_rd_err", resp_err[0], 1'b0);

        // reset mid-flight, LATENCY 4
        issue(2, 1'b0, 16'h0005, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_eq("mid_novalid", resp_valid[2], 1'b0);
            @(negedge clk);
        end
        issue(2, 1'b1, 16'h0021, 16'h5A5A);
        wait_resp(2, lat);
        check_eq("mid_lat", lat, 4);

        // continuous req_valid, LATENCY 3, four loads
        req_we[3] = 1'b0; req_addr[3] = 16'h0005; req_valid[3] = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            if (req_valid[3] && req_ready[3]) acc_e.push_back(t);
            @(posedge clk);
            @(negedge clk);
            if (acc_e.size() == 4) req_valid[3] = 1'b0;
            req_addr[3] = 16'h0005 + 16'(acc_e.size());
            if (resp_valid[3]) rsp_e.push_back(t + 1);
            if (t <= 11) check_eq("cont_busy", busy[3], 1'b1);
        end
        req_valid[3] = 1'b0;
        check_eq("cont_nacc", acc_e.size(), 4);
        check_eq("cont_nrsp", rsp_e.size(), 4);
        for (int n = 0; n < 4; n++) begin
            check_eq("cont_acc", (n < acc_e.size()) ? acc_e[n] : -1, 3 * n);
            check_eq("cont_rsp", (n < rsp_e.size()) ? rsp_e[n] : -1, 3 * n + 3);
        end

        // randomized traffic on all instances, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom_range(3) != 0);
                req_we[i]    = $urandom_range(1) == 1;
                req_wdata[i] = 16'($urandom);
                if ($urandom_range(9) == 0) req_addr[i] = 16'($urandom) | 16'h0400;
                else                        req_addr[i] = 16'($urandom_range(15));
                rst_n[i]     = ($urandom_range(199) != 0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            rst_n[i]     = 1'b1;
        end
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_dmem_responder
